// File: rtl/panel_pkg.sv
// Shared definitions for the front-panel I/O controller: FSM states,
// button indices and the hex-to-seven-segment lookup.
// Segment bit order is {g,f,e,d,c,b,a}. The segments are active-low.
package panel_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_LOAD = 2'd1,
        ST_RUN  = 2'd2,
        ST_VIEW = 2'd3
    } panel_state_t;

    localparam int NUM_BUTTONS = 5;
    localparam int BTN_LOAD    = 0;
    localparam int BTN_START   = 1;
    localparam int BTN_PREV    = 2;
    localparam int BTN_NEXT    = 3;
    localparam int BTN_CLEAR   = 4;

    // Active-low glyphs for 0..F.
    localparam logic [6:0] SEG_LUT [16] = '{
        7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
        7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
    };

    localparam logic [6:0] SEG_BLANK = 7'h7F;

endpackage

// File: rtl/panel_debounce.sv
// Debouncer for a single button.
// The accepted level follows the raw input only after the raw input has
// differed from it for DEBOUNCE_CYCLES consecutive cycles. Any agreement in
// that window restarts the count.
// A rising edge of the accepted level gives a one-cycle pulse. The pulse is
// registered one cycle after the level update.
// When PANEL_AUTOREPEAT_EN is defined, instances built with REPEAT_EN=1 also
// repeat the pulse while the button is held. Repetition starts
// 2*DEBOUNCE_CYCLES after the first pulse, at one pulse per DEBOUNCE_CYCLES.
module panel_debounce #(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter bit REPEAT_EN       = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic raw,
    output logic level,
    output logic pulse
);

    localparam int CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             level_q, level_d;
    logic             prev_q, prev_d;
    logic             pulse_q, pulse_d;
    logic             rpt_fire;

`ifdef PANEL_AUTOREPEAT_EN
    localparam int HOLD_W = $clog2(2 * DEBOUNCE_CYCLES + 1);
    localparam logic [HOLD_W-1:0] HOLD_ARM = HOLD_W'(2 * DEBOUNCE_CYCLES);

    logic [HOLD_W-1:0] hold_q, hold_d;
    logic [CNT_W-1:0]  per_q, per_d;
    logic              steady_high, armed;

    // Hold timer: it arms after 2*DEBOUNCE_CYCLES. After that, the period counter sets the repeat rate.
    always_comb begin
        steady_high = level_q & prev_q;
        armed       = (hold_q == HOLD_ARM);
        hold_d      = '0;
        per_d       = '0;
        if (steady_high) begin
            hold_d = armed ? hold_q : hold_q + 1'b1;
            if (armed) begin
                per_d = (per_q == CNT_LAST) ? '0 : per_q + 1'b1;
            end
        end
        rpt_fire = REPEAT_EN && steady_high && armed && (per_q == CNT_LAST);
    end

    // Registers for the hold timer and the repeat period.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            per_q  <= '0;
        end else begin
            hold_q <= hold_d;
            per_q  <= per_d;
        end
    end
`else
    logic unused_repeat;
    assign unused_repeat = REPEAT_EN;
    assign rpt_fire      = 1'b0;
`endif

    // Stability counter and edge detection for the accepted level.
    always_comb begin
        cnt_d   = '0;
        level_d = level_q;
        if (raw != level_q) begin
            if (cnt_q == CNT_LAST) begin
                level_d = raw;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        prev_d  = level_q;
        pulse_d = (level_q & ~prev_q) | rpt_fire;
    end

    // Debounce state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt_q   <= '0;
            level_q <= 1'b0;
            prev_q  <= 1'b0;
            pulse_q <= 1'b0;
        end else begin
            cnt_q   <= cnt_d;
            level_q <= level_d;
            prev_q  <= prev_d;
            pulse_q <= pulse_d;
        end
    end

    assign level = level_q;
    assign pulse = pulse_q;

endmodule

// File: rtl/panel_io_ctrl.sv
// Front-panel controller. It connects switches, buttons, LEDs and a
// multiplexed seven-segment display to a TPU. The TPU has a write port, a
// start strobe and a result read-back.
// The buttons are debounced one by one. A small FSM (IDLE/LOAD/RUN/VIEW)
// turns the debounced pulses into TPU writes, run starts and result browsing.
// Optional feature: define PANEL_AUTOREPEAT_EN to get auto-repeat on prev/next.
module panel_io_ctrl
    import panel_pkg::*;
#(
    parameter int DEBOUNCE_CYCLES = 1000000,
    parameter int DATA_W          = 8,
    parameter int ADDR_W          = 8,
    parameter int NUM_RESULTS     = 64,
    parameter int NUM_DIGITS      = 4,
    parameter int REFRESH_BITS    = 17
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [15:0]           switches,
    input  logic [4:0]            buttons,
    output logic [DATA_W-1:0]     tpu_data_out,
    output logic [ADDR_W-1:0]     tpu_addr,
    output logic                  tpu_write_enable,
    output logic                  tpu_start,
    output logic [ADDR_W-1:0]     result_addr,
    input  logic [DATA_W-1:0]     tpu_data_in,
    input  logic                  tpu_busy,
    input  logic                  tpu_done,
    output logic [15:0]           leds,
    output logic [6:0]            seg,
    output logic [NUM_DIGITS-1:0] an
);

    localparam logic [ADDR_W-1:0] ADDR_MAX = '1;
    localparam logic [ADDR_W-1:0] IDX_LAST = ADDR_W'(NUM_RESULTS - 1);

    logic [NUM_BUTTONS-1:0] btn_level;
    logic [NUM_BUTTONS-1:0] btn_pulse;

    for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_btn
        panel_debounce #(
            .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES),
            .REPEAT_EN      (i == BTN_PREV || i == BTN_NEXT)
        ) u_debounce (
            .clk  (clk),
            .rst  (rst),
            .raw  (buttons[i]),
            .level(btn_level[i]),
            .pulse(btn_pulse[i])
        );
    end

    logic unused_inputs;
    assign unused_inputs = ^{btn_level, switches, tpu_data_in};

    panel_state_t      state_q, state_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [ADDR_W-1:0] index_q, index_d;
    logic              full_q, full_d;
    logic              we_q, we_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              start_q, start_d;

    // Command decode. Only the highest-priority pulse acts:
    // clear > start > load > next > prev.
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        index_d     = index_q;
        full_d      = full_q;
        we_d        = 1'b0;
        addr_d      = addr_q;
        data_d      = data_q;
        start_d     = 1'b0;

        if (btn_pulse[BTN_CLEAR]) begin
            // Clearing does not stop a run that is already in progress in the TPU.
            state_d     = ST_IDLE;
            load_addr_d = '0;
            index_d     = '0;
            full_d      = 1'b0;
        end else if (btn_pulse[BTN_START]) begin
            if (!tpu_busy && state_q != ST_RUN) begin
                start_d = 1'b1;
                index_d = '0;
                state_d = ST_RUN;
            end
        end else if (btn_pulse[BTN_LOAD]) begin
            if (state_q != ST_RUN && !full_q) begin
                we_d    = 1'b1;
                addr_d  = load_addr_q;
                data_d  = switches[DATA_W-1:0];
                state_d = ST_LOAD;
                // The last address is written once. After that, the buffer is full.
                if (load_addr_q == ADDR_MAX) begin
                    full_d = 1'b1;
                end else begin
                    load_addr_d = load_addr_q + 1'b1;
                end
            end
        end else if (btn_pulse[BTN_NEXT]) begin
            if (state_q == ST_VIEW) begin
                index_d = (index_q == IDX_LAST) ? '0 : index_q + 1'b1;
            end
        end else if (btn_pulse[BTN_PREV]) begin
            if (state_q == ST_VIEW) begin
                index_d = (index_q == '0) ? IDX_LAST : index_q - 1'b1;
            end
        end

        if (state_q == ST_RUN && tpu_done && !btn_pulse[BTN_CLEAR]) begin
            state_d = ST_VIEW;
        end
    end

    // FSM and TPU-facing registers. Reset drops the write and start strobes at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            load_addr_q <= '0;
            index_q     <= '0;
            full_q      <= 1'b0;
            we_q        <= 1'b0;
            addr_q      <= '0;
            data_q      <= '0;
            start_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            index_q     <= index_d;
            full_q      <= full_d;
            we_q        <= we_d;
            addr_q      <= addr_d;
            data_q      <= data_d;
            start_q     <= start_d;
        end
    end

    assign tpu_write_enable = we_q;
    assign tpu_addr         = addr_q;
    assign tpu_data_out     = data_q;
    assign tpu_start        = start_q;
    assign result_addr      = index_q;

    logic [REFRESH_BITS-1:0] refresh_q, refresh_d;
    logic [15:0]             leds_q, leds_d;
    logic [6:0]              seg_q, seg_d;
    logic [NUM_DIGITS-1:0]   an_q, an_d;
    logic [7:0]              idx8, din8, ldaddr8;
    logic [15:0]             disp_val;
    logic [2:0]              digit_sel;
    logic [3:0]              nib;

    // LED word, display value and digit scan.
    always_comb begin
        idx8      = 8'(index_q);
        din8      = 8'(tpu_data_in);
        ldaddr8   = 8'(load_addr_q);
        leds_d    = {tpu_done, tpu_busy, full_q, idx8[4:0], din8};
        disp_val  = (state_q == ST_RUN) ? {8'hBB, ldaddr8} : {idx8, din8};
        refresh_d = refresh_q + 1'b1;
        digit_sel = 3'(refresh_q[REFRESH_BITS-1 -: 3] % NUM_DIGITS);

        // Digits 4..7 have no source nibble, so they show 0.
        nib = 4'h0;
        for (int k = 0; k < 4; k++) begin
            if (digit_sel == 3'(k)) begin
                nib = disp_val[4*k +: 4];
            end
        end
        seg_d = SEG_LUT[nib];

        an_d = '1;
        for (int k = 0; k < NUM_DIGITS; k++) begin
            if (digit_sel == 3'(k)) begin
                an_d[k] = 1'b0;
            end
        end
    end

    // Registered panel outputs. The display is blank while in reset.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            refresh_q <= '0;
            leds_q    <= '0;
            seg_q     <= SEG_BLANK;
            an_q      <= '1;
        end else begin
            refresh_q <= refresh_d;
            leds_q    <= leds_d;
            seg_q     <= seg_d;
            an_q      <= an_d;
        end
    end

    assign leds = leds_q;
    assign seg  = seg_q;
    assign an   = an_q;

endmodule

// File: tb/tb_panel_io_ctrl.sv
// Directed bench for panel_io_ctrl. It uses small parameters: debounce of 4 cycles, 3-bit addresses and 6 results.
module tb_panel_io_ctrl;
    import panel_pkg::*;

    localparam int DB = 4;
    localparam int DW = 8;
    localparam int AW = 3;
    localparam int NR = 6;
    localparam int ND = 4;
    localparam int RB = 5;

    logic          clk;
    logic          rst;
    logic [15:0]   switches;
    logic [4:0]    buttons;
    logic [DW-1:0] tpu_data_out;
    logic [AW-1:0] tpu_addr;
    logic          tpu_write_enable;
    logic          tpu_start;
    logic [AW-1:0] result_addr;
    logic [DW-1:0] tpu_data_in;
    logic          tpu_busy;
    logic          tpu_done;
    logic [15:0]   leds;
    logic [6:0]    seg;
    logic [ND-1:0] an;

    panel_io_ctrl #(
        .DEBOUNCE_CYCLES(DB),
        .DATA_W         (DW),
        .ADDR_W         (AW),
        .NUM_RESULTS    (NR),
        .NUM_DIGITS     (ND),
        .REFRESH_BITS   (RB)
    ) dut (
        .clk             (clk),
        .rst             (rst),
        .switches        (switches),
        .buttons         (buttons),
        .tpu_data_out    (tpu_data_out),
        .tpu_addr        (tpu_addr),
        .tpu_write_enable(tpu_write_enable),
        .tpu_start       (tpu_start),
        .result_addr     (result_addr),
        .tpu_data_in     (tpu_data_in),
        .tpu_busy        (tpu_busy),
        .tpu_done        (tpu_done),
        .leds            (leds),
        .seg             (seg),
        .an              (an)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;

    // Strobe monitors sample on the falling edge.
    int         we_cnt    = 0;
    int         start_cnt = 0;
    logic [7:0] addr_mask = '0;
    logic [7:0] last_data = '0;

    always @(negedge clk) begin
        if (tpu_write_enable === 1'b1) begin
            we_cnt              <= we_cnt + 1;
            addr_mask[tpu_addr] <= 1'b1;
            last_data           <= tpu_data_out;
        end
        if (tpu_start === 1'b1) begin
            start_cnt <= start_cnt + 1;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout required=finish");
        $fatal(1, "bench timeout");
    end

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic press(input int b);
        buttons[b] = 1'b1;
        tick(8);
        buttons[b] = 1'b0;
        tick(8);
    endtask

    task automatic wait_an(input logic [3:0] pat, input string tag);
        int k;
        k = 0;
        while (an !== pat && k < 40) begin
            tick(1);
            k++;
        end
        chk({tag, "_found"}, 32'(an), 32'(pat));
    endtask

    int         chg_tick [4];
    int         nchg;
    logic [2:0] prev_idx;

    initial begin
        rst         = 1'b1;
        switches    = 16'h005A;
        buttons     = '0;
        tpu_data_in = 8'h3C;
        tpu_busy    = 1'b0;
        tpu_done    = 1'b0;
        tick(2);

        // Reset values
        chk("rst_we",    32'(tpu_write_enable), 32'd0);
        chk("rst_start", 32'(tpu_start), 32'd0);
        chk("rst_addr",  32'(tpu_addr), 32'd0);
        chk("rst_data",  32'(tpu_data_out), 32'd0);
        chk("rst_ridx",  32'(result_addr), 32'd0);
        chk("rst_leds",  32'(leds), 32'd0);
        chk("rst_seg",   32'(seg), 32'h7F);
        chk("rst_an",    32'(an), 32'hF);
        chk("rst_state", 32'(dut.state_q), 32'(ST_IDLE));

        rst = 1'b0;
        tick(1);
        chk("an_onehot", 32'($countones(~an)), 32'd1);

        // A bouncing load button gives no write
        buttons[0] = 1'b1; tick(1);
        buttons[0] = 1'b0; tick(1);
        buttons[0] = 1'b1; tick(1);
        buttons[0] = 1'b0; tick(8);
        chk("bounce_no_write", 32'(we_cnt), 32'd0);

        // A stable press gives one write of switches[7:0] to address 0
        buttons[0] = 1'b1;
        tick(5);
        chk("load_not_yet", 32'(tpu_write_enable), 32'd0);
        tick(1);
        chk("load_we",   32'(tpu_write_enable), 32'd1);
        chk("load_addr", 32'(tpu_addr), 32'd0);
        chk("load_data", 32'(tpu_data_out), 32'h5A);
        tick(1);
        chk("load_we_1cyc", 32'(tpu_write_enable), 32'd0);
        buttons[0] = 1'b0;
        tick(8);
        chk("load_single", 32'(we_cnt), 32'd1);

        // Fill addresses 1..7. The extra press is ignored.
        for (int i = 0; i < 8; i++) begin
            switches = 16'hFF10 + 16'(i);
            press(BTN_LOAD);
        end
        chk("fill_count", 32'(we_cnt), 32'd8);
        chk("fill_mask",  32'(addr_mask), 32'hFF);
        chk("fill_last_addr", 32'(tpu_addr), 32'd7);
        chk("fill_last_data", 32'(last_data), 32'h16);
        chk("fill_full_led",  32'(leds[13]), 32'd1);

        // Start a run, let the TPU be busy, then finish
        buttons[1] = 1'b1;
        tick(6);
        chk("start_pulse", 32'(tpu_start), 32'd1);
        chk("start_state", 32'(dut.state_q), 32'(ST_RUN));
        chk("start_ridx",  32'(result_addr), 32'd0);
        tpu_busy = 1'b1;
        tick(1);
        chk("start_1cyc", 32'(tpu_start), 32'd0);
        buttons[1] = 1'b0;
        tick(9);
        tpu_busy = 1'b0;
        tpu_done = 1'b1;
        tick(1);
        tpu_done = 1'b0;
        chk("done_view",  32'(dut.state_q), 32'(ST_VIEW));
        chk("start_once", 32'(start_cnt), 32'd1);

        // A start press while the TPU is busy does nothing
        tpu_busy = 1'b1;
        press(BTN_START);
        chk("busy_start_ignored", 32'(start_cnt), 32'd1);
        chk("busy_state_view",    32'(dut.state_q), 32'(ST_VIEW));
        tpu_busy = 1'b0;

        // Index wrap-around in VIEW
        press(BTN_PREV);
        chk("prev_wrap", 32'(result_addr), 32'd5);
        press(BTN_NEXT);
        chk("next_wrap", 32'(result_addr), 32'd0);
        press(BTN_NEXT);
        chk("next_inc",  32'(result_addr), 32'd1);
        chk("leds_index", 32'(leds[12:8]), 32'd1);
        chk("leds_data",  32'(leds[7:0]), 32'h3C);
        chk("leds_flags", 32'(leds[15:13]), 32'b001);

        // Clear and next pressed together: clear wins
        buttons[4] = 1'b1;
        buttons[3] = 1'b1;
        tick(8);
        buttons = '0;
        tick(8);
        chk("clear_ridx",  32'(result_addr), 32'd0);
        chk("clear_state", 32'(dut.state_q), 32'(ST_IDLE));
        chk("clear_full",  32'(leds[13]), 32'd0);

        // Display in IDLE shows {index, data_in} = 0x003C
        wait_an(4'b1110, "dig0");
        chk("dig0_seg", 32'(seg), 32'h46);
        wait_an(4'b1101, "dig1");
        chk("dig1_seg", 32'(seg), 32'h30);
        wait_an(4'b1011, "dig2");
        chk("dig2_seg", 32'(seg), 32'h40);

        // Reset in the middle of a write cycle
        buttons[0] = 1'b1;
        tick(6);
        chk("midwr_we", 32'(tpu_write_enable), 32'd1);
        rst = 1'b1;
        #1;
        chk("midwr_rst_we",    32'(tpu_write_enable), 32'd0);
        chk("midwr_rst_start", 32'(tpu_start), 32'd0);
        buttons[0] = 1'b0;
        tick(2);
        rst = 1'b0;
        tick(12);
        chk("post_rst_writes", 32'(we_cnt), 32'd8);
        chk("post_rst_starts", 32'(start_cnt), 32'd1);

        // Go back to VIEW and hold next for 20 cycles
        press(BTN_START);
        tpu_done = 1'b1;
        tick(1);
        tpu_done = 1'b0;
        chk("rerun_view", 32'(dut.state_q), 32'(ST_VIEW));
        chk("rerun_starts", 32'(start_cnt), 32'd2);

        nchg     = 0;
        prev_idx = result_addr;
        buttons[3] = 1'b1;
        for (int n = 1; n <= 30; n++) begin
            if (n == 21) buttons[3] = 1'b0;
            tick(1);
            if (result_addr !== prev_idx) begin
                if (nchg < 4) chg_tick[nchg] = n;
                nchg++;
                prev_idx = result_addr;
            end
        end
        chk("hold_first_tick", 32'(chg_tick[0]), 32'd6);
`ifdef PANEL_AUTOREPEAT_EN
        chk("hold_changes", 32'(nchg), 32'd3);
        chk("hold_rpt1_gap", 32'(chg_tick[1] - chg_tick[0]), 32'd12);
        chk("hold_rpt2_gap", 32'(chg_tick[2] - chg_tick[0]), 32'd16);
        chk("hold_ridx", 32'(result_addr), 32'd3);
`else
        chk("hold_changes", 32'(nchg), 32'd1);
        chk("hold_ridx", 32'(result_addr), 32'd1);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/panel_io_ctrl.md
PANEL_IO_CTRL -- requirements
Module: panel_io_ctrl

Interface
REQ-001 Param: DEBOUNCE_CYCLES, 1000000, consecutive stable cycles before a button level is accepted.
REQ-002 Param: DATA_W, 8, TPU data width, taken from switches[DATA_W-1:0]; legal range 1..16.
REQ-003 Param: ADDR_W, 8, load/result address width.
REQ-004 Param: NUM_RESULTS, 64, number of viewable results; legal range 1..2**ADDR_W.
REQ-005 Param: NUM_DIGITS, 4, seven-segment digits multiplexed; legal range 1..8.
REQ-006 Param: REFRESH_BITS, 17, digit-scan divider width.
REQ-007 Port: clk  in  1  sole clock; all flops rising-edge.
REQ-008 Port: rst  in  1  asynchronous, active-high reset.
REQ-009 Port: switches  in  16  data entry.
REQ-010 Port: buttons  in  5  raw levels: [0] load, [1] start, [2] prev, [3] next, [4] clear.
REQ-011 Port: tpu_data_out  out  DATA_W, tpu_addr  out  ADDR_W, tpu_write_enable  out  1: write port.
REQ-012 Port: tpu_start  out  1; result_addr  out  ADDR_W (current result index).
REQ-013 Port: tpu_data_in  in  DATA_W; tpu_busy  in  1; tpu_done  in  1.
REQ-014 Port: leds  out  16; seg  out  7 (active-low); an  out  NUM_DIGITS (active-low).

Function
REQ-015 Each button is debounced by its own counter; the debounced level changes only after the raw level differs from it for DEBOUNCE_CYCLES consecutive cycles; any reversion restarts the counter.
REQ-016 Debounced rising edge produces exactly one 1-cycle pulse, registered one cycle after the level update.
REQ-017 FSM states IDLE, LOAD, RUN, VIEW; reset enters IDLE.
REQ-018 IDLE/LOAD/VIEW + load pulse: next cycle tpu_write_enable=1 for one cycle, tpu_addr=load_addr, tpu_data_out=switches[DATA_W-1:0]; load_addr increments; state LOAD.
REQ-019 load_addr saturates at 2**ADDR_W-1; once the write to that address has completed, further load pulses are ignored and the full flag is set.
REQ-020 Start pulse while tpu_busy=0 and state not RUN: tpu_start=1 for one cycle, result index cleared, state RUN; a start pulse while tpu_busy=1 is ignored.
REQ-021 RUN -> VIEW on tpu_done=1; load/prev/next pulses are ignored in RUN.
REQ-022 VIEW: next increments the index, wrapping NUM_RESULTS-1 -> 0; prev decrements it, wrapping 0 -> NUM_RESULTS-1.
REQ-023 Clear pulse in any state: load_addr=0, index=0, full=0, state IDLE; it does not affect an in-flight TPU run.
REQ-024 Simultaneous pulses in one cycle: priority clear > start > load > next > prev; only the winner acts.
REQ-025 leds = {tpu_done, tpu_busy, full, index[4:0], tpu_data_in zero-extended or truncated to 8}, registered.
REQ-026 Display value: in RUN, {8'hBB, load_addr[7:0]}; otherwise {index[7:0], tpu_data_in[7:0]}; digit k shows nibble k; digits 4..7 show 0.
REQ-027 Digit select = refresh_counter MSBs modulo NUM_DIGITS; exactly one anode is low at any time.

Reset
REQ-028 On rst: all outputs 0 except an, which is all-ones; seg = 7'h7F; counters, flags and debounced levels are 0.
REQ-029 Asserting rst mid-write or mid-run drops tpu_write_enable and tpu_start within the same cycle; the TPU is not re-started after release.

Configuration
REQ-030 With PANEL_AUTOREPEAT_EN defined: prev/next held for 2*DEBOUNCE_CYCLES after the first pulse repeat every DEBOUNCE_CYCLES while held. Without it: one pulse per press only.

Structure
REQ-031 Package panel_pkg holds the FSM state enum, button index constants and the hex-to-7-segment constant table.
REQ-032 A sub-module panel_debounce (one button: counter, level, edge pulse) is instantiated 5 times.

Verification (bench uses DEBOUNCE_CYCLES=4, ADDR_W=3, NUM_RESULTS=6)
REQ-033 Bounce load low/high/low for 3 cycles -> no pulse; then hold high 4 cycles -> single write, addr 0, data = switches[7:0]=8'h5A.
REQ-034 9 load presses -> writes to addr 0..7 only, full=1, leds[13]=1, and no 9th write.
REQ-035 Start, tpu_busy=1 for 10 cycles, then tpu_done -> one tpu_start pulse, VIEW state, result_addr=0; a second start while busy is ignored.
REQ-036 In VIEW, prev at index 0 -> index 5; next at index 5 -> index 0.
REQ-037 Clear and next pulsing in the same cycle -> index 0, IDLE; rst asserted mid-write -> tpu_write_enable=0 in that cycle.
REQ-038 With PANEL_AUTOREPEAT_EN, next held 20 cycles -> index advances at cycles 0, 12 and 16 after the first pulse.
